// File: rtl/mmio_pkg.sv
// Shared defaults, address-map helpers and region decode type for the MMIO memory block.
package mmio_pkg;

  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned RAM_AW_DEF = 14;
  localparam int unsigned SCR_AW_DEF = 13;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_SCR,
    RGN_KBD,
    RGN_NONE
  } region_e;

  // Screen window starts right after the data RAM.
  function automatic int unsigned scr_base(input int unsigned ram_aw);
    return 32'd1 << ram_aw;
  endfunction

  // Keyboard register sits on the first word past the screen window.
  function automatic int unsigned kbd_addr(input int unsigned ram_aw, input int unsigned scr_aw);
    return scr_base(ram_aw) + (32'd1 << scr_aw);
  endfunction

endpackage

// File: rtl/mmio_memory_mem_bank.sv
// Word memory with one write port, one combinational read port and one
// registered read-before-write port. Contents are not reset.
module mem_bank #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  input  logic          re_i,
  input  logic [AW-1:0] saddr_i,
  output logic [DW-1:0] sdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] sdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  // Non-blocking update of mem_q makes a same-edge write invisible here.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      sdata_q <= mem_q[saddr_i];
    end
  end

  assign sdata_o = sdata_q;

endmodule

// File: rtl/mmio_memory.sv
// CPU-visible memory map: data RAM, screen buffer with scanout port, and a
// keyboard register; illegal accesses raise a registered error pulse.
module mmio_memory
  import mmio_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RAM_AW = RAM_AW_DEF,
  parameter int unsigned SCR_AW = SCR_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAM_AW:0]   addr,
  input  logic [DW-1:0]     wdata,
  input  logic              we,
  output logic [DW-1:0]     rdata,
  output logic              err,
  input  logic [DW-1:0]     kbd_code,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  input  logic              scan_en,
  output logic [SCR_AW-1:0] scan_addr,
  output logic [DW-1:0]     scan_data,
  output logic              scan_vld,
  output logic              scan_sof
);

  localparam int unsigned AW = RAM_AW + 1;
  localparam logic [AW-1:0] SCR_BASE = AW'(scr_base(RAM_AW));
  localparam logic [AW-1:0] KBD_ADDR = AW'(kbd_addr(RAM_AW, SCR_AW));

  region_e           rgn;
  logic              ram_we;
  logic              scr_we;
  logic [DW-1:0]     ram_rdata;
  logic [DW-1:0]     scr_rdata;
  logic [DW-1:0]     unused_ram_sdata;

  logic              err_d,       err_q;
  logic [DW-1:0]     kbd_d,       kbd_q;
  logic [SCR_AW-1:0] cnt_d,       cnt_q;
  logic [SCR_AW-1:0] scan_addr_d, scan_addr_q;
  logic              scan_vld_d,  scan_vld_q;

  always_comb begin
    rgn = RGN_NONE;
    if (addr < SCR_BASE) begin
      rgn = RGN_RAM;
    end else if (addr < KBD_ADDR) begin
      rgn = RGN_SCR;
    end else if (addr == KBD_ADDR) begin
      rgn = RGN_KBD;
    end
  end

  // Writes are dropped while reset is held; memory contents survive reset.
  assign ram_we = rst_n & we & (rgn == RGN_RAM);
  assign scr_we = rst_n & we & (rgn == RGN_SCR);

  mem_bank #(
    .DW (DW),
    .AW (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (addr[RAM_AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (addr[RAM_AW-1:0]),
    .rdata_o (ram_rdata),
    .re_i    (1'b0),
    .saddr_i ('0),
    .sdata_o (unused_ram_sdata)
  );

  // Screen index is the low SCR_AW bits since SCR_BASE is a power of two.
  mem_bank #(
    .DW (DW),
    .AW (SCR_AW)
  ) u_scr (
    .clk_i   (clk),
    .we_i    (scr_we),
    .waddr_i (addr[SCR_AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (addr[SCR_AW-1:0]),
    .rdata_o (scr_rdata),
    .re_i    (scan_en),
    .saddr_i (cnt_q),
    .sdata_o (scan_data)
  );

  always_comb begin
    rdata = '0;
    case (rgn)
      RGN_RAM: rdata = ram_rdata;
      RGN_SCR: rdata = scr_rdata;
      RGN_KBD: rdata = kbd_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    err_d       = (rgn == RGN_NONE) | (we & (rgn == RGN_KBD));
    kbd_d       = kbd_q;
    cnt_d       = cnt_q;
    scan_addr_d = scan_addr_q;
    scan_vld_d  = scan_en;
    if (kbd_valid & kbd_ready) begin
      kbd_d = kbd_code;
    end
    if (scan_en) begin
      cnt_d       = cnt_q + 1'b1;
      scan_addr_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      kbd_q       <= '0;
      cnt_q       <= '0;
      scan_addr_q <= '0;
      scan_vld_q  <= 1'b0;
    end else begin
      err_q       <= err_d;
      kbd_q       <= kbd_d;
      cnt_q       <= cnt_d;
      scan_addr_q <= scan_addr_d;
      scan_vld_q  <= scan_vld_d;
    end
  end

  assign err       = err_q;
  assign kbd_ready = rst_n;
  assign scan_addr = scan_addr_q;
  assign scan_vld  = scan_vld_q;
  assign scan_sof  = scan_vld_q & (scan_addr_q == '0);

endmodule

// File: tb/tb_mmio_memory.sv
// Scoreboard bench for mmio_memory: stimulus pushes expectations from a
// behavioural memory-map model, a negedge monitor pops and compares.
module tb_mmio_memory;
  import mmio_pkg::*;

  localparam int unsigned DW     = 16;
  localparam int unsigned RAM_AW = 14;
  localparam int unsigned SCR_AW = 13;
  localparam int unsigned AW     = 15;
  localparam int RAM_W = 16384;
  localparam int SCR_W = 8192;
  localparam int SCR_B = 16384;
  localparam int KBD_A = 24576;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [DW-1:0]     wdata = '0;
  logic              we = 1'b0;
  logic [DW-1:0]     rdata;
  logic              err;
  logic [DW-1:0]     kbd_code = '0;
  logic              kbd_valid = 1'b0;
  logic              kbd_ready;
  logic              scan_en = 1'b0;
  logic [SCR_AW-1:0] scan_addr;
  logic [DW-1:0]     scan_data;
  logic              scan_vld;
  logic              scan_sof;

  always #5 clk = ~clk;

  mmio_memory #(
    .DW     (DW),
    .RAM_AW (RAM_AW),
    .SCR_AW (SCR_AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .err       (err),
    .kbd_code  (kbd_code),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready),
    .scan_en   (scan_en),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .scan_vld  (scan_vld),
    .scan_sof  (scan_sof)
  );

  // Reference model of the address map.
  logic [15:0] ram_m [RAM_W];
  bit          ram_ok[RAM_W];
  logic [15:0] scr_m [SCR_W];
  bit          scr_ok[SCR_W];
  logic [15:0] kbd_m = '0;
  int          cnt_m = 0;

  typedef struct { int tag; logic [15:0] val; } exp_t;
  typedef struct { int tag; int a; logic [15:0] d; } beat_t;
  exp_t  rd_q[$];
  exp_t  err_q[$];
  beat_t scan_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int a, input bit w, input logic [15:0] wd,
                      input bit kv, input logic [15:0] kc, input bit se);
    exp_t e;
    beat_t b;
    bit ok;
    bit er;
    logic [15:0] rv;
    cyc++;
    addr = AW'(a); we = w; wdata = wd; kbd_valid = kv; kbd_code = kc; scan_en = se;
    ok = 1'b1;
    rv = '0;
    if (a < SCR_B) begin
      ok = ram_ok[a]; rv = ram_m[a];
    end else if (a < KBD_A) begin
      ok = scr_ok[a-SCR_B]; rv = scr_m[a-SCR_B];
    end else if (a == KBD_A) begin
      rv = kbd_m;
    end
    if (ok) begin
      e.tag = cyc; e.val = rv; rd_q.push_back(e);
    end
    er = (a > KBD_A) || (w && a == KBD_A);
    e.tag = cyc + 1; e.val = {15'd0, er}; err_q.push_back(e);
    if (se) begin
      b.tag = cyc + 1; b.a = cnt_m; b.d = scr_m[cnt_m];
      scan_q.push_back(b);
      cnt_m = (cnt_m + 1) % SCR_W;
    end
    if (w && a < SCR_B) begin
      ram_m[a] = wd; ram_ok[a] = 1'b1;
    end else if (w && a < KBD_A) begin
      scr_m[a-SCR_B] = wd; scr_ok[a-SCR_B] = 1'b1;
    end
    if (kv) kbd_m = kc;
    @(posedge clk);
    #1;
  endtask

  exp_t  me;
  beat_t mb;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_q.size() > 0 && rd_q[0].tag == cyc) begin
        me = rd_q.pop_front();
        check("rdata", rdata, me.val);
      end
      if (err_q.size() > 0 && err_q[0].tag == cyc) begin
        me = err_q.pop_front();
        check("err", {15'd0, err}, me.val);
      end
      if (scan_vld) begin
        if (scan_q.size() == 0 || scan_q[0].tag != cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL scan_unexpected: got vld=1 addr=%0d at cycle %0d, required no beat", scan_addr, cyc);
        end else begin
          mb = scan_q.pop_front();
          check("scan_addr", 16'(scan_addr), 16'(mb.a));
          check("scan_data", scan_data, mb.d);
          check("scan_sof", {15'd0, scan_sof}, {15'd0, mb.a == 0});
        end
      end else begin
        check("scan_sof_idle", {15'd0, scan_sof}, 16'd0);
        if (scan_q.size() > 0 && scan_q[0].tag == cyc) begin
          mb = scan_q.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL scan_missing: got vld=0 at cycle %0d, required beat addr=%0d", cyc, mb.a);
        end
      end
    end
  end

  task automatic reset_checks();
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_scan_vld", {15'd0, scan_vld}, 16'd0);
    check("rst_scan_sof", {15'd0, scan_sof}, 16'd0);
    check("rst_kbd_ready", {15'd0, kbd_ready}, 16'd0);
    check("rst_scan_addr", 16'(scan_addr), 16'd0);
    check("rst_kbd_reg", rdata, 16'd0);
  endtask

  initial begin
    int r;
    int a;
    int left;
    addr = AW'(KBD_A);
    #2;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic region writes and read-back.
    step(0, 1, 16'h1234, 0, 0, 0);
    step(SCR_B, 1, 16'hBEEF, 0, 0, 0);
    step(KBD_A-1, 1, 16'h00FF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(SCR_B, 0, 0, 0, 0, 0);
    step(KBD_A-1, 0, 0, 0, 0, 0);

    // Keyboard load, then illegal write to the keyboard register.
    step(0, 0, 0, 1, 16'h0041, 0);
    step(KBD_A, 0, 0, 0, 0, 0);
    step(KBD_A, 1, 16'h7777, 0, 0, 0);
    step(KBD_A, 0, 0, 0, 0, 0);
    step(KBD_A, 0, 0, 0, 0, 0);

    // Unmapped read and write.
    step(KBD_A+1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(32767, 1, 16'hDEAD, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(KBD_A-1, 0, 0, 0, 0, 0);
    step(SCR_B, 0, 0, 0, 0, 0);

    // Preload screen word k with k.
    for (int k = 0; k < SCR_W; k++) step(SCR_B + k, 1, 16'(k), 0, 0, 0);

    // Full frame plus two, a 3-cycle gap after word 100, and a same-word write at 200.
    for (int i = 0; i < 101; i++) step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 101; i < SCR_W + 2; i++) begin
      if (cnt_m == 200) step(SCR_B + 200, 1, 16'hAAAA, 0, 0, 1);
      else step(0, 0, 0, 0, 0, 1);
    end
    step(SCR_B + 200, 0, 0, 0, 0, 0);

    // Randomized traffic over all regions.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) a = $urandom_range(0, 255);
      else if (r < 7) a = SCR_B + $urandom_range(0, SCR_W - 1);
      else if (r == 7) a = KBD_A;
      else a = KBD_A + 1 + $urandom_range(0, 8190);
      step(a, $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 4) == 0,
           16'($urandom), $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 1);
    mon_en = 1'b0;
    rd_q.delete(); err_q.delete(); scan_q.delete();
    addr = AW'(KBD_A); we = 1'b0; scan_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    addr = AW'(SCR_B + 5); we = 1'b1; wdata = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    we = 1'b0;
    rst_n = 1'b1;
    kbd_m = '0;
    cnt_m = 0;
    mon_en = 1'b1;
    step(SCR_B + 5, 0, 0, 0, 0, 0);
    step(KBD_A, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    left = 0;
    foreach (rd_q[i])   if (rd_q[i].tag <= cyc) left++;
    foreach (err_q[i])  if (err_q[i].tag <= cyc) left++;
    foreach (scan_q[i]) if (scan_q[i].tag <= cyc) left++;
    n_cmp++;
    if (left != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unconsumed expectations, required 0", left);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
